seg_shift_rx: RTL and testbench

SEG_SHIFT_RX -- requirements
Module: seg_shift_rx

---
 rtl/seg_rx_pkg.sv | 12 +
 rtl/sig_sync_edge.sv | 46 ++++
 rtl/seg_shift_rx.sv | 77 +++++++
 tb/tb_seg_shift_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_rx_pkg.sv
// Shared constants and types for the serial display-frame receiver.
package seg_rx_pkg;
  localparam int FRAME_BITS_DEF = 64;
  localparam int CNT_SAT_DEF    = FRAME_BITS_DEF + 1;

  typedef logic [FRAME_BITS_DEF-1:0] frame_t;

  // The bit counter stops one past a full frame so that "too long" stays distinguishable.
  function automatic int cnt_sat(input int frame_bits);
    return frame_bits + 1;
  endfunction
endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer, optional glitch filter and rising-edge detect for one input.
// Filter enabled by defining SEG_SHIFT_RX_GLITCH_FILTER_EN.
module sig_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sig,
  output logic rise
);
  logic [1:0] sync_q, sync_d;
  logic       hist_q, hist_d;

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  logic [1:0] filt_q, filt_d;

  // The filtered level only moves once three consecutive synced samples agree.
  always_comb begin
    filt_d = {filt_q[0], sync_q[1]};
    sig    = hist_q;
    if ((sync_q[1] == filt_q[0]) && (sync_q[1] == filt_q[1])) sig = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) filt_q <= '0;
    else     filt_q <= filt_d;
  end
`else
  always_comb sig = sync_q[1];
`endif

  always_comb begin
    sync_d = {sync_q[0], din};
    hist_d = sig;
    rise   = sig & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
endmodule

// File: rtl/seg_shift_rx.sv
// Captures MSB-first serial display frames clocked by seg_clk and latched by seg_en.
// Optional input glitch filter: define SEG_SHIFT_RX_GLITCH_FILTER_EN.
module seg_shift_rx
  import seg_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_do,
  input  logic                  seg_en,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  len_err,
  output logic                  overrun
);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat(FRAME_BITS));
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  logic clk_rise, en_rise, do_sig, clk_sig_unused, en_sig_unused;

  sig_sync_edge u_clk_sync (.clk(clk), .rst(rst), .din(seg_clk), .sig(clk_sig_unused), .rise(clk_rise));
  sig_sync_edge u_do_sync  (.clk(clk), .rst(rst), .din(seg_do),  .sig(do_sig),         .rise());
  sig_sync_edge u_en_sync  (.clk(clk), .rst(rst), .din(seg_en),  .sig(en_sig_unused),  .rise(en_rise));

  logic [FRAME_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  valid_q, valid_d, len_err_q, len_err_d, overrun_q, overrun_d;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    len_err_d = len_err_q;
    overrun_d = overrun_q;
    if (clk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], do_sig};
      if (bit_cnt_q != CNT_SAT) bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (valid_q && frame_ready) valid_d = 1'b0;
    // A latch sees the shift from the same cycle, and wins over a simultaneous accept.
    if (en_rise) begin
      data_d    = shift_d;
      len_err_d = (bit_cnt_d != CNT_FULL);
      valid_d   = 1'b1;
      if (valid_q && !frame_ready) overrun_d = 1'b1;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      len_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      len_err_q <= len_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign len_err     = len_err_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_seg_shift_rx.sv
// Randomized bench for seg_shift_rx against a bit-history reference model.
// Glitch-filter scenario runs only when SEG_SHIFT_RX_GLITCH_FILTER_EN is defined.
module tb_seg_shift_rx;
  import seg_rx_pkg::*;

  logic   clk = 1'b0, rst = 1'b1, seg_clk = 1'b0, seg_do = 1'b0, seg_en = 1'b0, frame_ready = 1'b0;
  frame_t frame_data;
  logic   frame_valid, len_err, overrun;

  int     tests = 0, fails = 0;
  bit     hist[$];
  int     bits_since_latch = 0;
  logic   m_valid = 1'b0, m_overrun = 1'b0, m_len_err = 1'b0;
  frame_t m_frame = '0;

  always #5 clk = ~clk;

  seg_shift_rx dut (
    .clk(clk), .rst(rst), .seg_clk(seg_clk), .seg_do(seg_do), .seg_en(seg_en),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .len_err(len_err), .overrun(overrun)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected register contents: the most recent 64 bits shifted since reset, zero padded.
  function automatic frame_t last_bits();
    frame_t r = '0;
    for (int i = 0; i < 64; i++) begin
      int idx = hist.size() - 64 + i;
      r = {r[62:0], (idx >= 0) ? hist[idx] : 1'b0};
    end
    return r;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    seg_do = b;
    wait_cyc(2);
    seg_clk = 1'b1;
    wait_cyc(4);
    seg_clk = 1'b0;
    wait_cyc(4);
    hist.push_back(b);
    bits_since_latch++;
  endtask

  task automatic send_word(input frame_t w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic model_latch();
    m_frame   = last_bits();
    m_len_err = (bits_since_latch != 64);
    if (m_valid) m_overrun = 1'b1;
    m_valid = 1'b1;
    bits_since_latch = 0;
  endtask

  task automatic do_latch();
    seg_en = 1'b1;
    wait_cyc(4);
    seg_en = 1'b0;
    wait_cyc(8);
    model_latch();
  endtask

  task automatic accept();
    frame_ready = 1'b1;
    wait_cyc(1);
    frame_ready = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    hist.delete();
    bits_since_latch = 0;
    m_valid = 1'b0; m_overrun = 1'b0; m_len_err = 1'b0; m_frame = '0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (frame_data !== 64'h0) begin fails++; $display("FAIL reset_data: got %h expected 0", frame_data); end
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
    tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    $display("[TB] reset: data=%h valid=%b len_err=%b overrun=%b", frame_data, frame_valid, len_err, overrun);
  endtask

  task automatic test_full_frame();
    send_word(64'hDEADBEEF_01234567, 64);
    do_latch();
    tests++; if (frame_data !== 64'hDEADBEEF01234567) begin fails++; $display("FAIL full_data: got %h expected deadbeef01234567", frame_data); end
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL full_valid: got %b expected 1", frame_valid); end
    tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL full_len_err: got %b expected 0", len_err); end
    $display("[TB] full frame: data=%h valid=%b len_err=%b", frame_data, frame_valid, len_err);
    accept();
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL accept_clear: got %b expected 0", frame_valid); end
  endtask

  task automatic test_length_errors();
    for (int i = 0; i < 63; i++) send_bit(1'($urandom));
    do_latch();
    tests++; if (frame_data !== m_frame) begin fails++; $display("FAIL short_data: got %h expected %h", frame_data, m_frame); end
    tests++; if (len_err !== 1'b1) begin fails++; $display("FAIL short_len_err: got %b expected 1", len_err); end
    $display("[TB] 63-bit frame: data=%h len_err=%b", frame_data, len_err);
    accept();
    for (int i = 0; i < 70; i++) send_bit(1'($urandom));
    wait_cyc(8);
    tests++; if (dut.bit_cnt_q !== 8'd65) begin fails++; $display("FAIL sat_cnt: got %0d expected 65", dut.bit_cnt_q); end
    do_latch();
    tests++; if (frame_data !== m_frame) begin fails++; $display("FAIL long_data: got %h expected %h", frame_data, m_frame); end
    tests++; if (len_err !== 1'b1) begin fails++; $display("FAIL long_len_err: got %b expected 1", len_err); end
    $display("[TB] 70-bit frame: data=%h len_err=%b", frame_data, len_err);
    accept();
  endtask

  task automatic test_same_cycle();
    bit b;
    for (int i = 0; i < 63; i++) send_bit(1'($urandom));
    b = 1'($urandom);
    seg_do = b;
    wait_cyc(2);
    seg_clk = 1'b1; seg_en = 1'b1;
    wait_cyc(4);
    seg_clk = 1'b0; seg_en = 1'b0;
    wait_cyc(8);
    hist.push_back(b);
    bits_since_latch++;
    model_latch();
    tests++; if (frame_data !== m_frame) begin fails++; $display("FAIL same_data: got %h expected %h", frame_data, m_frame); end
    tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL same_len_err: got %b expected 0", len_err); end
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL same_valid: got %b expected 1", frame_valid); end
    $display("[TB] same-cycle clk+en: data=%h len_err=%b", frame_data, len_err);
    accept();
  endtask

  task automatic test_overrun();
    frame_t a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send_word(a, 64);
    do_latch();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_first: got %b expected 0", overrun); end
    send_word(b, 64);
    do_latch();
    tests++; if (frame_data !== b) begin fails++; $display("FAIL ovr_data: got %h expected %h", frame_data, b); end
    tests++; if (overrun !== m_overrun) begin fails++; $display("FAIL ovr_set: got %b expected %b", overrun, m_overrun); end
    tests++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b expected 1", frame_valid); end
    accept();
    wait_cyc(3);
    accept();
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    tests++; if (frame_valid !== m_valid) begin fails++; $display("FAIL ovr_accept: got %b expected %b", frame_valid, m_valid); end
    $display("[TB] overrun: data=%h overrun=%b valid=%b", frame_data, overrun, frame_valid);
  endtask

  task automatic test_reset_mid_frame();
    frame_t w;
    w = {$urandom, $urandom};
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    do_reset();
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL mid_ovr_clear: got %b expected 0", overrun); end
    send_word(w, 64);
    tests++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL mid_spurious: got %b expected 0", frame_valid); end
    do_latch();
    tests++; if (frame_data !== w) begin fails++; $display("FAIL mid_data: got %h expected %h", frame_data, w); end
    tests++; if (len_err !== 1'b0) begin fails++; $display("FAIL mid_len_err: got %b expected 0", len_err); end
    $display("[TB] reset mid-frame then frame: data=%h len_err=%b", frame_data, len_err);
    accept();
  endtask

`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    do_reset();
    seg_clk = 1'b1;
    wait_cyc(1);
    seg_clk = 1'b0;
    wait_cyc(10);
    tests++; if (dut.bit_cnt_q !== 8'd0) begin fails++; $display("FAIL glitch_no_shift: got %0d expected 0", dut.bit_cnt_q); end
    seg_clk = 1'b1;
    wait_cyc(3);
    seg_clk = 1'b0;
    wait_cyc(1);
    tests++; if (dut.bit_cnt_q !== 8'd0) begin fails++; $display("FAIL glitch_early: got %0d expected 0 after 4 edges", dut.bit_cnt_q); end
    wait_cyc(1);
    tests++; if (dut.bit_cnt_q !== 8'd1) begin fails++; $display("FAIL glitch_edge5: got %0d expected 1 after 5 edges", dut.bit_cnt_q); end
    wait_cyc(10);
    tests++; if (dut.bit_cnt_q !== 8'd1) begin fails++; $display("FAIL glitch_once: got %0d expected 1", dut.bit_cnt_q); end
    $display("[TB] glitch filter: bit_cnt=%0d", dut.bit_cnt_q);
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_length_errors();
    test_same_cycle();
    test_overrun();
    test_reset_mid_frame();
`ifdef SEG_SHIFT_RX_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
